// File: rtl/sp1_ope_unit_pkg.sv
// Shared constants for the sp1 operator unit: default data width and reset level.
package sp1_ope_unit_pkg;

  localparam int unsigned DW_DEFAULT = 16;
  localparam logic        RST_ACTIVE = 1'b0;

endpackage

// File: rtl/sp1_ope_unit_if.sv
// Operand/result bundle for sp1_ope_unit; master issues operands, slave returns results.
// Handshake: valid-only. in_valid marks operands captured at the next rising edge;
// out_valid is high for exactly the cycle after each capture. There is no ready.
interface sp1_ope_unit_if #(
  parameter int DW = 16
);

  logic          in_valid;
  logic [DW-1:0] a0;
  logic [DW-1:0] a1;
  logic          out_valid;
  logic [DW-1:0] y;
  logic          c;
  logic          eq;
  logic          gt;

  modport master (
    output in_valid, a0, a1,
    input  out_valid, y, c, eq, gt
  );

  modport slave (
    input  in_valid, a0, a1,
    output out_valid, y, c, eq, gt
  );

endinterface

// File: rtl/sp1_ope_unit_cores.sv
// Clockless leaf cores: DW-bit adder with carry-out, equality and unsigned greater-than.
module sp1_adder #(
  parameter int DW = 16
) (
  input  logic [DW-1:0] a0,
  input  logic [DW-1:0] a1,
  output logic [DW-1:0] y,
  output logic          c
);

  // Zero-extend both operands so the carry lands in the extra bit.
  assign {c, y} = {1'b0, a0} + {1'b0, a1};

endmodule

module sp1_comp_eq #(
  parameter int DW = 16
) (
  input  logic [DW-1:0] a0,
  input  logic [DW-1:0] a1,
  output logic          eq
);

  assign eq = (a0 == a1);

endmodule

module sp1_comp_gt #(
  parameter int DW = 16
) (
  input  logic [DW-1:0] a0,
  input  logic [DW-1:0] a1,
  output logic          gt
);

  assign gt = (a0 > a1);

endmodule

// File: rtl/sp1_ope_unit_reg.sv
// Enable register with asynchronous active-low clear holding the packed result {y, c, eq, gt}.
module sp1_ope_reg
  import sp1_ope_unit_pkg::*;
#(
  parameter int W = 19
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ACTIVE) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/sp1_ope_unit.sv
// Registered add/compare operator: one-cycle latency, one result per cycle, no backpressure.
module sp1_ope_unit
  import sp1_ope_unit_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  sp1_ope_unit_if.slave bus
);

  logic [DW-1:0] sum_y;
  logic          sum_c;
  logic          cmp_eq;
  logic          cmp_gt;
  logic [DW+2:0] res_d;
  logic [DW+2:0] res_q;
  logic          valid_q;

  sp1_adder #(.DW(DW)) u_adder (
    .a0 (bus.a0),
    .a1 (bus.a1),
    .y  (sum_y),
    .c  (sum_c)
  );

  sp1_comp_eq #(.DW(DW)) u_comp_eq (
    .a0 (bus.a0),
    .a1 (bus.a1),
    .eq (cmp_eq)
  );

  sp1_comp_gt #(.DW(DW)) u_comp_gt (
    .a0 (bus.a0),
    .a1 (bus.a1),
    .gt (cmp_gt)
  );

  assign res_d = {sum_y, sum_c, cmp_eq, cmp_gt};

  // Result fields only load on issue, so they hold the last result while idle.
  sp1_ope_reg #(.W(DW + 3)) u_reg (
    .clk (clk),
    .rst (rst),
    .en  (bus.in_valid),
    .d   (res_d),
    .q   (res_q)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ACTIVE) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= bus.in_valid;
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.y         = res_q[DW+2:3];
  assign bus.c         = res_q[2];
  assign bus.eq        = res_q[1];
  assign bus.gt        = res_q[0];

endmodule

// File: tb/tb_sp1_ope_unit.sv
// Bench for sp1_ope_unit: directed vector table at DW=16, reset sequences, random sweeps at DW=8 and DW=1.
module tb_sp1_ope_unit;

  logic clk = 1'b0;
  logic rst = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  sp1_ope_unit_if #(.DW(16)) bus16 ();
  sp1_ope_unit_if #(.DW(8))  bus8 ();
  sp1_ope_unit_if #(.DW(1))  bus1 ();

  sp1_ope_unit #(.DW(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));
  sp1_ope_unit #(.DW(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));
  sp1_ope_unit #(.DW(1))  dut1  (.clk(clk), .rst(rst), .bus(bus1));

  // clock/reset block
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation still running, expected finish");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic        vld;
    logic [15:0] a0;
    logic [15:0] a1;
    logic        exp_ov;
    logic [15:0] exp_y;
    logic        exp_c;
    logic        exp_eq;
    logic        exp_gt;
  } vec_t;

  vec_t vecs[12];

  logic [8+3:0] exp8_q[$];
  logic [1+3:0] exp1_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check16(input string tag, input logic ov, input logic [15:0] y,
                         input logic c, input logic eq, input logic gt);
    check({tag, ".out_valid"}, 32'(bus16.out_valid), 32'(ov));
    check({tag, ".y"},         32'(bus16.y),         32'(y));
    check({tag, ".c"},         32'(bus16.c),         32'(c));
    check({tag, ".eq"},        32'(bus16.eq),        32'(eq));
    check({tag, ".gt"},        32'(bus16.gt),        32'(gt));
  endtask

  task automatic drive16(input logic vld, input logic [15:0] a0, input logic [15:0] a1);
    bus16.in_valid = vld;
    bus16.a0       = a0;
    bus16.a1       = a1;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [16:0] s16;
    logic [15:0] ra0, ra1;
    logic [8:0]  s8;
    logic [7:0]  a08, a18;
    logic [1:0]  s1;
    logic        a01, a11, v8, v1;
    logic [11:0] m8, e8, act8;
    logic [4:0]  m1, e1, act1;

    vecs[0]  = '{1'b1, 16'hFFFF, 16'h0001, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[1]  = '{1'b1, 16'h1234, 16'h1234, 1'b1, 16'h2468, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 16'h0001, 16'h8000, 1'b1, 16'h8001, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 16'h7FFF, 16'h8001, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 16'h00FF, 16'h0001, 1'b1, 16'h0100, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 16'hAAAA, 16'h5555, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{1'b0, 16'hFFFF, 16'hFFFF, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 16'h8000, 16'h7FFF, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFE, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 16'h8001, 16'h7FFF, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[11] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};

    bus8.in_valid = 1'b0; bus8.a0 = '0; bus8.a1 = '0;
    bus1.in_valid = 1'b0; bus1.a0 = '0; bus1.a1 = '0;

    // Reset held for 5 cycles with live operands: nothing may be captured.
    for (int i = 0; i < 5; i++) begin
      drive16(1'b1, 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)));
      cycle();
      check16("reset_hold", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    end

    // Release away from the edge; first edge captures the current operands.
    @(negedge clk);
    ra0 = 16'($urandom_range(0, 65535));
    ra1 = 16'($urandom_range(0, 65535));
    drive16(1'b1, ra0, ra1);
    rst = 1'b1;
    cycle();
    s16 = {1'b0, ra0} + {1'b0, ra1};
    check16("first_capture", 1'b1, s16[15:0], s16[16], ra0 == ra1, ra0 > ra1);

    // Directed vector table, applied back-to-back.
    for (int i = 0; i < 12; i++) begin
      drive16(vecs[i].vld, vecs[i].a0, vecs[i].a1);
      cycle();
      check16($sformatf("vec%0d", i), vecs[i].exp_ov, vecs[i].exp_y,
              vecs[i].exp_c, vecs[i].exp_eq, vecs[i].exp_gt);
    end

    // Asynchronous reset mid-cycle while a result is valid.
    drive16(1'b1, 16'h4000, 16'h0001);
    cycle();
    check16("pre_async", 1'b1, 16'h4001, 1'b0, 1'b0, 1'b1);
    #3;
    rst = 1'b0;
    #1;
    check16("async_clear", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    cycle();
    check16("async_held", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    drive16(1'b1, 16'h0003, 16'h0003);
    cycle();
    check16("post_async", 1'b1, 16'h0006, 1'b0, 1'b1, 1'b0);
    drive16(1'b0, 16'h0000, 16'h0000);

    // Random sweeps on the narrow instances against a reference model.
    m8 = '0;
    m1 = '0;
    for (int i = 0; i < 10000; i++) begin
      v8  = 1'($urandom_range(0, 3) != 0);
      a08 = 8'($urandom_range(0, 255));
      a18 = 8'($urandom_range(0, 255));
      v1  = 1'($urandom_range(0, 1));
      a01 = 1'($urandom_range(0, 1));
      a11 = 1'($urandom_range(0, 1));
      bus8.in_valid = v8; bus8.a0 = a08; bus8.a1 = a18;
      bus1.in_valid = v1; bus1.a0 = a01; bus1.a1 = a11;

      s8 = {1'b0, a08} + {1'b0, a18};
      if (v8) m8 = {1'b1, s8[7:0], s8[8], a08 == a18, a08 > a18};
      else    m8 = {1'b0, m8[10:0]};
      exp8_q.push_back(m8);

      s1 = {1'b0, a01} + {1'b0, a11};
      if (v1) m1 = {1'b1, s1[0], s1[1], a01 == a11, a01 > a11};
      else    m1 = {1'b0, m1[3:0]};
      exp1_q.push_back(m1);

      cycle();

      e8 = exp8_q.pop_front();
      act8 = {bus8.out_valid, bus8.y, bus8.c, bus8.eq, bus8.gt};
      check($sformatf("sweep8[%0d]", i), 32'(act8), 32'(e8));
      e1 = exp1_q.pop_front();
      act1 = {bus1.out_valid, bus1.y, bus1.c, bus1.eq, bus1.gt};
      check($sformatf("sweep1[%0d]", i), 32'(act1), 32'(e1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sp1_ope_unit.md
Name: sp1_ope_unit

Overview:
Registered arithmetic/compare operator for the sp1 datapath. It takes two DW-bit unsigned operands and produces, in one clocked result, four values: the sum with carry-out, an equality flag and an unsigned greater-than flag. The combinational cores sp1_adder, sp1_comp_eq and sp1_comp_gt sit behind a single output register stage with a valid qualifier. Execute-stage logic consumes the result one cycle after issue.

Parameters:
DW, 16, operand/result data width in bits (legal DW >= 1).

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-low reset (asserted when 0).
in_valid  input  1  operands on a0/a1 are valid this cycle.
a0  input  DW  operand 0, unsigned.
a1  input  DW  operand 1, unsigned.
out_valid  output  1  y/c/eq/gt hold a result issued the previous cycle.
y  output  DW  registered sum (a0 + a1) mod 2^DW.
c  output  1  registered carry-out of the DW-bit add.
eq  output  1  registered flag, 1 when a0 == a1.
gt  output  1  registered flag, 1 when a0 > a1, unsigned.

Behaviour:
- Combinational cores, exact semantics:
  - sp1_adder: {c, y} = a0 + a1, zero-extended to DW+1 bits; no carry-in.
  - sp1_comp_eq: eq = (a0 == a1).
  - sp1_comp_gt: gt = (a0 > a1), unsigned.
  - No X-propagation tricks.
- Reset (rst = 0, asynchronous, takes effect immediately without a clock edge):
  - out_valid = 0, y = 0, c = 0, eq = 0, gt = 0.
  - Deassertion is synchronised by the integrator; first capture happens at the first rising edge with rst = 1.
- Latency is exactly 1 cycle:
  - in_valid = 1 at edge N: y/c/eq/gt capture the core outputs for that a0/a1, and out_valid = 1 after edge N.
  - in_valid = 0 at an edge: out_valid = 0; y/c/eq/gt hold their previous values (no capture).
- Throughput: one operation per cycle; back-to-back in_valid is fully supported, with no stall or backpressure.
- Boundary cases:
  - Wrap-around: all-ones + 1 gives y = 0, c = 1.
  - 0 + 0 gives y = 0, c = 0, eq = 1, gt = 0.
  - Comparisons are unsigned, so MSB-set operands compare as large.
  - a0 == a1 always gives gt = 0.
- Flag invariant: eq and gt are never both 1 in any captured result.
- Reset mid-operation: an operation captured or pending when rst falls is discarded; out_valid drops to 0 immediately.
- Commutativity: y and c are independent of operand order; gt is not.
- Width rule: no internal truncation other than the stated mod 2^DW on y.

Decomposition:
- Shared package/header (sp1_common): default DW and the reset-active level constant.
- Leaf combinational modules: sp1_adder (parameter DW; ports a0, a1, y, c), sp1_comp_eq (a0, a1, eq), sp1_comp_gt (a0, a1, gt).
  - Each is usable stand-alone, with no clock.
- sp1_ope_unit instantiates the three leaves plus the register stage.
- The single natural extra sub-module is sp1_ope_reg: a DW+3-bit enable register with async active-low clear, holding {y, c, eq, gt}.
  - out_valid is a plain async-cleared flop.

Test Plan:
1. Reset: hold rst = 0 for 5 clk cycles with random a0/a1 and in_valid = 1 -> out_valid = 0 and y/c/eq/gt all 0 throughout; first edge after release captures the current operands.
2. DW = 16, a0 = 0xFFFF, a1 = 0x0001, in_valid = 1 -> next cycle y = 0x0000, c = 1, eq = 0, gt = 1, out_valid = 1.
3. a0 = a1 = 0x1234 -> y = 0x2468, c = 0, eq = 1, gt = 0; then a0 = 0x0001, a1 = 0x8000 -> y = 0x8001, c = 0, eq = 0, gt = 0 (unsigned).
4. Back-to-back issue of 0x7FFF + 0x8001 then 0x00FF + 0x0001 -> consecutive results {y = 0x0000, c = 1, gt = 0} then {y = 0x0100, c = 0, gt = 1}, with out_valid high both cycles.
5. in_valid = 0 with changing operands -> out_valid = 0 and y/c/eq/gt unchanged from the last captured result.
6. Assert rst asynchronously mid-cycle while out_valid = 1 -> all outputs 0 before the next clk edge; random 10k-vector sweep with DW = 8 and DW = 1 checked against a reference model {c, y} = a0 + a1, eq = (a0 == a1), gt = (a0 > a1).
